// File: rtl/seq_check_pkg.sv
// Shared definitions for the serial pattern detector.
//   SEQ_LEN_MIN / SEQ_LEN_MAX : legal range of the pattern length parameter
//   pattern_t                 : container type for the PATTERN parameter; only
//                               the low LEN bits are significant
package seq_check_pkg;

  localparam int unsigned SEQ_LEN_MIN = 2;
  localparam int unsigned SEQ_LEN_MAX = 16;

  typedef logic [SEQ_LEN_MAX-1:0] pattern_t;

endpackage

// File: rtl/seq_check_if.sv
// Serial stream interface of the pattern detector.
//   data_in : serial bit, sampled by the detector on every rising clk edge
//   flag    : one-cycle registered match pulse from the detector
//   master  : stream source / flag consumer
//   slave   : the detector itself
interface seq_check_if;

  logic data_in;
  logic flag;

  modport master (output data_in, input  flag);
  modport slave  (input  data_in, output flag);

endinterface

// File: rtl/seq_check.sv
// Serial bit-pattern detector. Shifts one bit of bus.data_in in per rising
// clk edge and pulses bus.flag for one cycle whenever the last LEN samples
// equal PATTERN[LEN-1:0] (oldest sample compared against PATTERN[LEN-1]).
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_check_if.slave (data_in in, flag out)
// Parameters:
//   LEN     : pattern length, 2..16
//   PATTERN : target sequence, truncated to LEN bits
//   OVERLAP : 1 = matches may share bits, 0 = history restarts after a match
module seq_check
  import seq_check_pkg::*;
#(
  parameter int unsigned LEN     = 5,
  parameter pattern_t    PATTERN = pattern_t'(5'b10010),
  parameter bit          OVERLAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_check_if.slave  bus
);

  if (LEN < SEQ_LEN_MIN || LEN > SEQ_LEN_MAX) begin : g_bad_len
    $error("seq_check: LEN=%0d outside legal range 2..16", LEN);
  end

  localparam int unsigned    FILL_W = $clog2(LEN + 1);
  localparam logic [LEN-1:0] PAT    = PATTERN[LEN-1:0];

  logic [LEN-1:0]    hist;
  logic [LEN-1:0]    hist_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              match;

  // The fill counter saturates at LEN; requiring it to be full stops the
  // zero-reset history from aliasing an all-zero (or zero-prefixed) pattern.
  always_comb begin
    hist_next = {hist[LEN-2:0], bus.data_in};
    fill_next = (fill == FILL_W'(LEN)) ? fill : fill + FILL_W'(1);
    match     = (fill_next == FILL_W'(LEN)) && (hist_next == PAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      fill     <= '0;
      bus.flag <= 1'b0;
    end else begin
      bus.flag <= match;
      if (match && !OVERLAP) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_next;
        fill <= fill_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_check.sv
module tb_seq_check;

  localparam int unsigned LEN  = 5;
  localparam int unsigned NDUT = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            din   = 1'b0;
  logic [NDUT-1:0] flags;

  // 0: 10010 overlap, 1: 10010 no-overlap, 2: 00000 overlap, 3: 00000 no-overlap
  seq_check_if ifs[NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam logic [15:0] DUT_PAT = (g < 2) ? 16'h0012 : 16'h0000;
    localparam bit          DUT_OVL = ((g % 2) == 0);
    assign ifs[g].data_in = din;
    assign flags[g]       = ifs[g].flag;
    seq_check #(.LEN(LEN), .PATTERN(DUT_PAT), .OVERLAP(DUT_OVL)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifs[g])
    );
  end

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: per DUT, the list of bits received since the last
  // reset/clear, trimmed to the newest LEN; a match is a full window equal to
  // the pattern read oldest-first.
  bit [LEN-1:0]    ref_pat [NDUT] = '{5'b10010, 5'b10010, 5'b00000, 5'b00000};
  bit              ref_ovl [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit              hq [NDUT][$];
  logic [NDUT-1:0] exp_f;
  logic [NDUT-1:0] got_f;
  logic [15:0]     obs [NDUT];
  int unsigned     edge_no;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      hq[k].delete();
      obs[k] = '0;
    end
    edge_no = 0;
  endtask

  task automatic step(input logic d);
    bit hit;
    din = d;
    @(posedge clk);
    #1;
    edge_no++;
    got_f = flags;
    for (int k = 0; k < NDUT; k++) begin
      hq[k].push_back(d);
      if (hq[k].size() > LEN) void'(hq[k].pop_front());
      hit = (hq[k].size() == LEN);
      for (int unsigned i = 0; i < LEN; i++)
        if (hit && hq[k][i] != ref_pat[k][LEN-1-i]) hit = 1'b0;
      exp_f[k] = hit;
      if (hit && !ref_ovl[k]) hq[k].delete();
      if (edge_no <= 16) obs[k][edge_no-1] = got_f[k];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      din = 1'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if (flags !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: flags=%b expected 0000", flags);
      end
    end
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < int'(LEN) - 1; i++) begin
      step(1'($urandom));
      n_checks++;
      if (got_f !== '0) begin
        n_fail++;
        $display("FAIL reset_fill edge %0d: flags=%b expected 0000", edge_no, got_f);
      end
    end
  endtask

  task automatic test_defaults();
    logic [15:0] stream;
    stream = 16'h6D29;  // 0,1,1,0,1,1,0,1,0,0,1,0,1,0,0,1
    apply_reset();
    for (int i = 15; i >= 0; i--) begin
      step(stream[i]);
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL defaults edge %0d: flags=%b expected %b", edge_no, got_f, exp_f);
      end
    end
    n_checks++;
    if (obs[0] !== 16'h0800) begin
      n_fail++;
      $display("FAIL defaults_pulse_pos: got %b expected %b", obs[0], 16'h0800);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] stream;
    stream = 8'b1001_0010;
    apply_reset();
    for (int i = 7; i >= 0; i--) begin
      step(stream[i]);
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL overlap edge %0d: flags=%b expected %b", edge_no, got_f, exp_f);
      end
    end
    n_checks++;
    if (obs[0][7:0] !== 8'h90) begin
      n_fail++;
      $display("FAIL overlap_on_pos: got %b expected %b", obs[0][7:0], 8'h90);
    end
    n_checks++;
    if (obs[1][7:0] !== 8'h10) begin
      n_fail++;
      $display("FAIL overlap_off_pos: got %b expected %b", obs[1][7:0], 8'h10);
    end
  endtask

  task automatic test_fill_guard();
    apply_reset();
    repeat (7) begin
      step(1'b0);
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL fill_guard edge %0d: flags=%b expected %b", edge_no, got_f, exp_f);
      end
    end
    n_checks++;
    if (obs[2][6:0] !== 7'h70) begin
      n_fail++;
      $display("FAIL fill_guard_ovl_pos: got %b expected %b", obs[2][6:0], 7'h70);
    end
    n_checks++;
    if (obs[3][6:0] !== 7'h10) begin
      n_fail++;
      $display("FAIL fill_guard_noovl_pos: got %b expected %b", obs[3][6:0], 7'h10);
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] pat;
    pat = 5'b10010;
    apply_reset();
    for (int i = 4; i >= 1; i--) step(pat[i]);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
    step(1'b0);
    n_checks++;
    if (got_f[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_flag: flag=%b expected 0", got_f[0]);
    end
    for (int i = 4; i >= 0; i--) begin
      step(pat[i]);
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d: flags=%b expected %b", edge_no, got_f, exp_f);
      end
    end
    n_checks++;
    if (got_f[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_flag: flag=%b expected 1", got_f[0]);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] pat;
    pat = 5'b10010;
    apply_reset();
    for (int i = 4; i >= 0; i--) step(pat[i]);
    n_checks++;
    if (got_f[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_flag: flag=%b expected 1", got_f[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (flags !== '0) begin
      n_fail++;
      $display("FAIL async_drop: flags=%b expected 0000", flags);
    end
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    bit pend[$];
    logic [4:0] pat;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      if (pend.size() == 0) begin
        if ($urandom_range(3) == 0) begin
          pat = ($urandom_range(1) == 0) ? 5'b10010 : 5'b00000;
          for (int i = 4; i >= 0; i--) pend.push_back(pat[i]);
        end else begin
          pend.push_back(1'($urandom));
        end
      end
      step(pend.pop_front());
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++;
        $display("FAIL random step %0d: flags=%b expected %b", n, got_f, exp_f);
      end
      if ($urandom_range(99) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (flags !== '0) begin
          n_fail++;
          $display("FAIL random_reset step %0d: flags=%b expected 0000", n, flags);
        end
        rst_n = 1'b1;
        model_clear();
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_defaults();
    test_overlap();
    test_fill_guard();
    test_mid_reset();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
